msi_line_controller: RTL
========================

Name: msi_line_controller

Overview:
- Processor-side and snoop-side MSI controller for one cache line.
- Reads the line's state/address/data and drives its write port; owns the CPU request handshake and the shared snooping bus.
- One instance sits between each CPU and its cache line storage.
- MSI encoding: 00 Invalid, 01 Shared, 10 Modified, 11 treated as Invalid.

Parameters:
- ADDR_W, 3, line/tag address width.
- DATA_W, 4, data word width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU request strobe, sampled in IDLE only.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  request address.
- cpu_wdata  in  DATA_W  write data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read result, valid with cpu_ready, held until the next completion.
- blk_state  in  2  line's current state.
- blk_addr  in  ADDR_W  line's current address.
- blk_data  in  DATA_W  line's current data.
- blk_write  out  1  line write enable.
- blk_state_o  out  2  new state for the line.
- blk_addr_o  out  ADDR_W  new address for the line.
- blk_data_o  out  DATA_W  new data for the line.
- bus_req  out  1  bus request to the arbiter.
- bus_grant  in  1  bus granted to this controller.
- bus_msg  out  2  00 none, 01 read miss, 10 write miss, 11 invalidate.
- bus_addr  out  ADDR_W  address of the message or writeback.
- bus_wb  out  1  writeback strobe.
- bus_wb_data  out  DATA_W  writeback data.
- mem_valid  in  1  memory fill data valid.
- mem_data  in  DATA_W  memory fill data.
- snoop_valid  in  1  another cache's message is on the bus.
- snoop_msg  in  2  snooped message, same encoding as bus_msg.
- snoop_addr  in  ADDR_W  snooped address.

Behaviour:
- Reset (async): FSM to IDLE; all outputs 0, including cpu_rdata; latched request cleared.
- States: IDLE, LOOKUP, ARB, MEM_WAIT, FILL.
- IDLE: on cpu_req, latch cpu_we/cpu_addr/cpu_wdata, go to LOOKUP.
- LOOKUP: hit = (blk_addr == latched addr) and state is S or M.
  - Read hit: cpu_rdata <= blk_data, pulse cpu_ready, go to IDLE. Latency: ready on the 2nd edge after cpu_req.
  - Write hit in M: blk_write with (M, addr, wdata), pulse cpu_ready, go to IDLE.
  - Write hit in S: pending = INV, go to ARB.
  - Miss, with victim in M: pending = WB followed by miss, go to ARB.
  - Miss otherwise: pending = RD miss (read) or WR miss (write), go to ARB.
- ARB: hold bus_req=1 until bus_grant. In the first granted cycle:
  - WB: bus_wb=1, bus_addr=blk_addr, bus_wb_data=blk_data; blk_write the line to Invalid; then the miss is pending and bus_req stays asserted.
  - INV: bus_msg=11; blk_write (M, addr, wdata); pulse cpu_ready; drop bus_req; go to IDLE.
  - RD/WR miss: bus_msg=01/10 for one cycle; go to MEM_WAIT.
- MEM_WAIT: bus_req stays 1. Wait for mem_valid (unbounded), then go to FILL with mem_data captured.
- FILL: blk_write (S, addr, mem_data) for a read, or (M, addr, wdata) for a write.
  - Read: cpu_rdata = mem_data.
  - Pulse cpu_ready, drop bus_req, go to IDLE.
- Snoop hit = snoop_valid and snoop_addr == blk_addr and state is not Invalid.
- The bus guarantees no snoop_valid while this controller's bus_grant=1.
- Snoop actions:
  - Read miss on M: bus_wb pulse with blk_data; line to S.
  - Write miss on M: writeback; line to I.
  - Write miss or invalidate on S: line to I.
  - Read miss on S: no action.
- A snoop write has priority on blk_write. In that cycle the FSM holds its state and issues no CPU or bus action except the snoop writeback. The FSM re-evaluates with the updated line next cycle.
- Race: a snoop invalidates the line while pending = INV in ARB. Pending becomes WR miss; the miss path completes normally.
- bus_msg, bus_wb and blk_write are single-cycle pulses. bus_addr and bus_wb_data are 0 when unused.

Optional Feature:
- Macro: MSI_LINE_CTRL_STATS_EN.
- When defined: adds outputs hit_count[7:0] and miss_count[7:0].
  - Counted once per request, decided in LOOKUP. An upgrade from S counts as a hit.
  - Counters saturate at 255 and reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Read miss, line I: cpu read addr 3 -> bus_msg=01, addr 3; mem_data=4'hA -> line (S,3,A); cpu_rdata=A; cpu_ready.
- Read hit, line (S,3,A): read addr 3 -> cpu_ready 2 edges after cpu_req; cpu_rdata=A; no bus_req.
- Write upgrade, line (S,3,A): write 4'h5 -> bus_msg=11 on grant; line (M,3,5); cpu_ready.
- Dirty victim, line (M,3,5): read addr 6 -> bus_wb with addr 3, data 5; then bus_msg=01, addr 6; mem 4'h2 -> line (S,6,2).
- Snoop read miss on (M,6,7) in IDLE -> bus_wb data 7; line becomes (S,6,7).
- Race: pending INV on addr 6 with snoop invalidate at addr 6 before grant -> bus_msg=10; fill ends with line (M,6,wdata).
- Async reset asserted during MEM_WAIT -> all outputs 0 immediately; next cpu_req is serviced from IDLE.

Source files
------------

// File: rtl/msi_line_controller.sv
// MSI coherence controller for one cache line: CPU request FSM plus snoop responder.
// Build option MSI_LINE_CTRL_STATS_EN adds saturating hit/miss counters.
`timescale 1ns/1ps
module msi_line_controller #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [1:0]        blk_state,
    input  logic [ADDR_W-1:0] blk_addr,
    input  logic [DATA_W-1:0] blk_data,
    output logic              blk_write,
    output logic [1:0]        blk_state_o,
    output logic [ADDR_W-1:0] blk_addr_o,
    output logic [DATA_W-1:0] blk_data_o,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [1:0]        bus_msg,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wb,
    output logic [DATA_W-1:0] bus_wb_data,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_msg,
    input  logic [ADDR_W-1:0] snoop_addr,
`ifdef MSI_LINE_CTRL_STATS_EN
    output logic [7:0]        hit_count,
    output logic [7:0]        miss_count,
`endif
    output logic [2:0]        dbg_state
);
    // Handshakes: cpu_req is a one-cycle strobe taken only in IDLE and answered by a
    // one-cycle cpu_ready; bus_req is held high until this controller has finished its
    // bus transaction, and bus actions are issued only in cycles where bus_grant is high.
    localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b10;
    localparam logic [1:0] MSG_NONE = 2'b00, MSG_RD = 2'b01, MSG_WR = 2'b10, MSG_INV = 2'b11;

    typedef enum logic [2:0] {IDLE, LOOKUP, ARB, MEM_WAIT, FILL} state_t;
    typedef enum logic [1:0] {P_RD, P_WR, P_INV, P_WB} pend_t;

    state_t            state;
    pend_t             pending;
    pend_t             miss_kind;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] fill_data;
    logic              mem_got;

    logic [1:0]        line_state;
    logic [ADDR_W-1:0] line_addr;
    logic [DATA_W-1:0] line_data;
    logic              line_s, line_m, hit, snoop_hit, snoop_wb, snoop_act;

    // The line storage lags our registered write by one cycle, so forward it.
    always_comb begin
        line_state = blk_write ? blk_state_o : blk_state;
        line_addr  = blk_write ? blk_addr_o  : blk_addr;
        line_data  = blk_write ? blk_data_o  : blk_data;
        miss_kind  = req_we ? P_WR : P_RD;
    end

    assign line_s    = (line_state == ST_S);
    assign line_m    = (line_state == ST_M);
    assign hit       = (line_addr == req_addr) && (line_s || line_m);
    assign snoop_hit = snoop_valid && (snoop_addr == line_addr) && (line_s || line_m);
    // Any foreign request against a Modified line forces a writeback.
    assign snoop_wb  = snoop_hit && line_m && (snoop_msg != MSG_NONE);
    assign snoop_act = snoop_wb || (snoop_hit && line_s && snoop_msg[1]);
    assign dbg_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= P_RD;
            req_we      <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            fill_data   <= '0;
            mem_got     <= 1'b0;
            cpu_ready   <= 1'b0;
            cpu_rdata   <= '0;
            blk_write   <= 1'b0;
            blk_state_o <= ST_I;
            blk_addr_o  <= '0;
            blk_data_o  <= '0;
            bus_req     <= 1'b0;
            bus_msg     <= MSG_NONE;
            bus_addr    <= '0;
            bus_wb      <= 1'b0;
            bus_wb_data <= '0;
        end else begin
            cpu_ready   <= 1'b0;
            blk_write   <= 1'b0;
            blk_state_o <= ST_I;
            blk_addr_o  <= '0;
            blk_data_o  <= '0;
            bus_msg     <= MSG_NONE;
            bus_addr    <= '0;
            bus_wb      <= 1'b0;
            bus_wb_data <= '0;
            if (snoop_act) begin
                blk_write   <= 1'b1;
                blk_state_o <= (line_m && snoop_msg == MSG_RD) ? ST_S : ST_I;
                blk_addr_o  <= line_addr;
                blk_data_o  <= line_data;
                if (line_m) begin
                    bus_wb      <= 1'b1;
                    bus_addr    <= line_addr;
                    bus_wb_data <= line_data;
                end
                // Line left S/M under us: an upgrade or victim writeback becomes a plain miss.
                if (state == ARB && (pending == P_INV || pending == P_WB))
                    pending <= miss_kind;
                if (state == MEM_WAIT && mem_valid && !mem_got) begin
                    fill_data <= mem_data;
                    mem_got   <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (cpu_req) begin
                            req_we    <= cpu_we;
                            req_addr  <= cpu_addr;
                            req_wdata <= cpu_wdata;
                            state     <= LOOKUP;
                        end
                    end
                    LOOKUP: begin
                        if (hit && !req_we) begin
                            cpu_rdata <= line_data;
                            cpu_ready <= 1'b1;
                            state     <= IDLE;
                        end else if (hit && line_m) begin
                            blk_write   <= 1'b1;
                            blk_state_o <= ST_M;
                            blk_addr_o  <= req_addr;
                            blk_data_o  <= req_wdata;
                            cpu_ready   <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            if (hit)         pending <= P_INV;
                            else if (line_m) pending <= P_WB;
                            else             pending <= miss_kind;
                            bus_req <= 1'b1;
                            state   <= ARB;
                        end
                    end
                    ARB: begin
                        if (bus_grant) begin
                            case (pending)
                                P_WB: begin
                                    bus_wb      <= 1'b1;
                                    bus_addr    <= line_addr;
                                    bus_wb_data <= line_data;
                                    blk_write   <= 1'b1;
                                    blk_state_o <= ST_I;
                                    blk_addr_o  <= line_addr;
                                    blk_data_o  <= line_data;
                                    pending     <= miss_kind;
                                end
                                P_INV: begin
                                    bus_msg     <= MSG_INV;
                                    bus_addr    <= req_addr;
                                    blk_write   <= 1'b1;
                                    blk_state_o <= ST_M;
                                    blk_addr_o  <= req_addr;
                                    blk_data_o  <= req_wdata;
                                    cpu_ready   <= 1'b1;
                                    bus_req     <= 1'b0;
                                    state       <= IDLE;
                                end
                                default: begin
                                    bus_msg  <= (pending == P_WR) ? MSG_WR : MSG_RD;
                                    bus_addr <= req_addr;
                                    mem_got  <= 1'b0;
                                    state    <= MEM_WAIT;
                                end
                            endcase
                        end
                    end
                    MEM_WAIT: begin
                        if (mem_valid || mem_got) begin
                            if (!mem_got) fill_data <= mem_data;
                            mem_got <= 1'b0;
                            state   <= FILL;
                        end
                    end
                    FILL: begin
                        blk_write   <= 1'b1;
                        blk_state_o <= req_we ? ST_M : ST_S;
                        blk_addr_o  <= req_addr;
                        blk_data_o  <= req_we ? req_wdata : fill_data;
                        if (!req_we) cpu_rdata <= fill_data;
                        cpu_ready   <= 1'b1;
                        bus_req     <= 1'b0;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef MSI_LINE_CTRL_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP && !snoop_act) begin
            if (hit) begin
                if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
            end else if (miss_count != 8'hFF) begin
                miss_count <= miss_count + 8'd1;
            end
        end
    end
`endif
endmodule
